// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if -- operation/result bundle for the alu_seq execute-stage ALU.
//
// Signals (directions seen from the ALU, i.e. the slave modport):
//   iStart     in   1         start strobe, accepted only while oBusy=0
//   iOp        in   4         opcode, sampled with iStart
//   iA, iB     in   DATASIZE  operands
//   iFlagLoad  in   1         load flag register from iF
//   iF         in   8         flag value for iFlagLoad
//   oR         out  DATASIZE  result register (product low half for MUL)
//   oRH        out  DATASIZE  product high half, 0 after any non-MUL op
//   oF         out  8         flag register
//   oBusy      out  1         multiply in progress
//   oDone      out  1         one-cycle pulse when oR/oRH/oF were updated
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int DATASIZE = 8
);
  logic                iStart;
  logic [3:0]          iOp;
  logic [DATASIZE-1:0] iA;
  logic [DATASIZE-1:0] iB;
  logic                iFlagLoad;
  logic [7:0]          iF;
  logic [DATASIZE-1:0] oR;
  logic [DATASIZE-1:0] oRH;
  logic [7:0]          oF;
  logic                oBusy;
  logic                oDone;

  modport master (
    output iStart, iOp, iA, iB, iFlagLoad, iF,
    input  oR, oRH, oF, oBusy, oDone
  );

  modport slave (
    input  iStart, iOp, iA, iB, iFlagLoad, iF,
    output oR, oRH, oF, oBusy, oDone
  );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered 8085-style flag ALU with a multi-cycle unsigned
// shift-add multiplier.
//
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous, active-high reset
//   bus  slave modport of alu_seq_if (operands, opcode, flag load, results)
//
// Single-cycle ops register oR/oRH/oF at the accepting edge and pulse oDone
// in the following cycle. MUL (opcode F) latches its operands, performs one
// shift-add step per edge and writes the 2*DATASIZE product at the
// DATASIZE-th edge after acceptance.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int DATASIZE = 8,
  parameter int CARRY_F  = 0,
  parameter int PARITY_F = 2,
  parameter int AUXC_F   = 4,
  parameter int ZERO_F   = 6,
  parameter int SIGN_F   = 7
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int W  = DATASIZE;
  localparam int CW = $clog2(DATASIZE + 1);

  // Flag bits 1, 3 and 5 do not exist and always read as 0.
  localparam logic [7:0] FLAG_MASK = 8'b1101_0101;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2,
                         OP_SBB = 4'h3, OP_ANA = 4'h4, OP_XRA = 4'h5,
                         OP_ORA = 4'h6, OP_CMP = 4'h7, OP_INR = 4'h8,
                         OP_DCR = 4'h9, OP_RLC = 4'hA, OP_RRC = 4'hB,
                         OP_RAL = 4'hC, OP_RAR = 4'hD, OP_CMC = 4'hE,
                         OP_MUL = 4'hF;

  state_e         state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   rh_q, rh_d;
  logic [7:0]     f_q, f_d;
  logic           done_q, done_d;
  logic           busy;

  // Multiplier working registers.
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   prod_hi_q, prod_hi_d;
  logic [W-1:0]   prod_lo_q, prod_lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Single-cycle ALU result.
  logic [W-1:0]   alu_r;
  logic [7:0]     alu_f;
  logic           alu_wr_r;

  // One shift-add step of the multiplier.
  logic [W:0]     step_sum;
  logic [W-1:0]   step_hi;
  logic [W-1:0]   step_lo;
  logic [7:0]     mul_f;

  logic           mul_last;

  assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(DATASIZE - 1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.iStart && (bus.iOp == OP_MUL)) state_d = S_MUL;
      S_MUL:  if (mul_last)                          state_d = S_IDLE;
      default:                                       state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == S_MUL);
  end

  // -------------------------------------------------------------------------
  // Single-cycle ALU
  // -------------------------------------------------------------------------
  always_comb begin
    logic [W:0] sum_ext;
    logic       cin;
    logic       cy;
    logic       ac;
    logic       upd_zspa;   // op updates Z, S, P and AC

    cin      = f_q[CARRY_F];
    sum_ext  = '0;
    alu_r    = '0;
    cy       = f_q[CARRY_F];
    ac       = f_q[AUXC_F];
    upd_zspa = 1'b1;
    alu_wr_r = 1'b1;

    unique case (bus.iOp)
      OP_ADD, OP_ADC: begin
        sum_ext = {1'b0, bus.iA} + {1'b0, bus.iB}
                + {{W{1'b0}}, (bus.iOp == OP_ADC) & cin};
        alu_r   = sum_ext[W-1:0];
        cy      = sum_ext[W];
        // Carry into bit 4 recovered from the sum: a ^ b ^ s at that bit.
        ac      = sum_ext[4] ^ bus.iA[4] ^ bus.iB[4];
      end
      OP_SUB, OP_CMP: begin
        sum_ext  = {1'b0, bus.iA} - {1'b0, bus.iB};
        alu_r    = sum_ext[W-1:0];
        cy       = sum_ext[W];
        ac       = bus.iA[3:0] < bus.iB[3:0];
        alu_wr_r = (bus.iOp == OP_SUB);
      end
      OP_SBB: begin
        sum_ext = {1'b0, bus.iA} - {1'b0, bus.iB} - {{W{1'b0}}, cin};
        alu_r   = sum_ext[W-1:0];
        cy      = sum_ext[W];
        ac      = {1'b0, bus.iA[3:0]} < ({1'b0, bus.iB[3:0]} + {4'b0, cin});
      end
      OP_ANA: begin
        alu_r = bus.iA & bus.iB;
        cy    = 1'b0;
        ac    = bus.iA[3] | bus.iB[3];
      end
      OP_XRA: begin
        alu_r = bus.iA ^ bus.iB;
        cy    = 1'b0;
        ac    = 1'b0;
      end
      OP_ORA: begin
        alu_r = bus.iA | bus.iB;
        cy    = 1'b0;
        ac    = 1'b0;
      end
      OP_INR: begin
        alu_r = bus.iA + W'(1);
        ac    = (bus.iA[3:0] == 4'hF);
      end
      OP_DCR: begin
        alu_r = bus.iA - W'(1);
        ac    = (bus.iA[3:0] == 4'h0);
      end
      OP_RLC: begin
        alu_r    = {bus.iA[W-2:0], bus.iA[W-1]};
        cy       = bus.iA[W-1];
        upd_zspa = 1'b0;
      end
      OP_RRC: begin
        alu_r    = {bus.iA[0], bus.iA[W-1:1]};
        cy       = bus.iA[0];
        upd_zspa = 1'b0;
      end
      OP_RAL: begin
        alu_r    = {bus.iA[W-2:0], cin};
        cy       = bus.iA[W-1];
        upd_zspa = 1'b0;
      end
      OP_RAR: begin
        alu_r    = {cin, bus.iA[W-1:1]};
        cy       = bus.iA[0];
        upd_zspa = 1'b0;
      end
      OP_CMC: begin
        cy       = ~cin;
        upd_zspa = 1'b0;
        alu_wr_r = 1'b0;
      end
      default: begin
        // MUL is handled by the multi-cycle path.
        upd_zspa = 1'b0;
        alu_wr_r = 1'b0;
      end
    endcase

    alu_f          = f_q;
    alu_f[CARRY_F] = cy;
    if (upd_zspa) begin
      alu_f[ZERO_F]   = (alu_r == '0);
      alu_f[SIGN_F]   = alu_r[W-1];
      alu_f[PARITY_F] = ~^alu_r;
      alu_f[AUXC_F]   = ac;
    end
    alu_f = alu_f & FLAG_MASK;
  end

  // -------------------------------------------------------------------------
  // Multiplier step: add the multiplicand when the multiplier LSB is set,
  // then shift {hi, lo} right by one. After DATASIZE steps {hi, lo} holds
  // the full product and the multiplier bits have all been consumed.
  // -------------------------------------------------------------------------
  always_comb begin
    step_sum = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
    step_hi  = step_sum[W:1];
    step_lo  = {step_sum[0], prod_lo_q[W-1:1]};

    mul_f           = 8'h00;
    mul_f[ZERO_F]   = ({step_hi, step_lo} == '0);
    mul_f[CARRY_F]  = (step_hi != '0);
    mul_f[SIGN_F]   = step_hi[W-1];
    mul_f[PARITY_F] = ~^step_lo;
    mul_f           = mul_f & FLAG_MASK;
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    r_d       = r_q;
    rh_d      = rh_q;
    f_d       = f_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    cnt_d     = cnt_q;

    if (state_q == S_IDLE) begin
      if (bus.iStart) begin
        if (bus.iOp == OP_MUL) begin
          mcand_d   = bus.iA;
          prod_hi_d = '0;
          prod_lo_d = bus.iB;
          cnt_d     = '0;
        end else begin
          if (alu_wr_r) r_d = alu_r;
          rh_d   = '0;
          f_d    = alu_f;
          done_d = 1'b1;
        end
      end else if (bus.iFlagLoad) begin
        f_d = bus.iF & FLAG_MASK;
      end
    end else begin
      prod_hi_d = step_hi;
      prod_lo_d = step_lo;
      cnt_d     = cnt_q + CW'(1);
      if (mul_last) begin
        r_d    = step_lo;
        rh_d   = step_hi;
        f_d    = mul_f;
        done_d = 1'b1;
      end
    end
  end

  // Architecturally visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      rh_q   <= '0;
      f_q    <= '0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      rh_q   <= rh_d;
      f_q    <= f_d;
      done_q <= done_d;
    end
  end

  // NOTE: the multiplier working registers need no reset; they are always
  // loaded at MUL acceptance before any step reads them.
  always_ff @(posedge clk) begin
    mcand_q   <= mcand_d;
    prod_hi_q <= prod_hi_d;
    prod_lo_q <= prod_lo_d;
    cnt_q     <= cnt_d;
  end

  assign bus.oR    = r_q;
  assign bus.oRH   = rh_q;
  assign bus.oF    = f_q;
  assign bus.oBusy = busy;
  assign bus.oDone = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq at DATASIZE=8 and DATASIZE=16.
// Stimulus pushes hand-computed expected results into per-DUT queues; a
// monitor per DUT pops and compares on every oDone pulse.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;

  alu_seq_if #(.DATASIZE(8))  b8 ();
  alu_seq_if #(.DATASIZE(16)) b16 ();

  alu_seq #(.DATASIZE(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8));
  alu_seq #(.DATASIZE(16)) dut16 (.clk(clk), .rst(rst16), .bus(b16));

  typedef struct {
    logic [15:0] r;
    logic [15:0] rh;
    logic [7:0]  f;
    string       tag;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b8.oDone === 1'b1) begin
        if (q8.size() == 0) begin
          check("dut8_unexpected_done", 32'(b8.oDone), 32'd0);
        end else begin
          e = q8.pop_front();
          check({e.tag, ".oR"},  32'(b8.oR),  32'(e.r));
          check({e.tag, ".oRH"}, 32'(b8.oRH), 32'(e.rh));
          check({e.tag, ".oF"},  32'(b8.oF),  32'(e.f));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b16.oDone === 1'b1) begin
        if (q16.size() == 0) begin
          check("dut16_unexpected_done", 32'(b16.oDone), 32'd0);
        end else begin
          e = q16.pop_front();
          check({e.tag, ".oR"},  32'(b16.oR),  32'(e.r));
          check({e.tag, ".oRH"}, 32'(b16.oRH), 32'(e.rh));
          check({e.tag, ".oF"},  32'(b16.oF),  32'(e.f));
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic idle8();
    b8.iStart = 1'b0; b8.iOp = 4'h0; b8.iA = '0; b8.iB = '0;
    b8.iFlagLoad = 1'b0; b8.iF = 8'h00;
  endtask

  task automatic idle16();
    b16.iStart = 1'b0; b16.iOp = 4'h0; b16.iA = '0; b16.iB = '0;
    b16.iFlagLoad = 1'b0; b16.iF = 8'h00;
  endtask

  task automatic start8(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    b8.iStart = 1'b1; b8.iOp = op; b8.iA = a; b8.iB = b;
    @(negedge clk);
    idle8();
  endtask

  task automatic op8(input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] er,
                     input logic [7:0] erh, input logic [7:0] ef,
                     input string tag);
    q8.push_back('{16'(er), 16'(erh), ef, tag});
    start8(op, a, b);
  endtask

  task automatic fload8(input logic [7:0] f);
    b8.iFlagLoad = 1'b1; b8.iF = f;
    @(negedge clk);
    idle8();
  endtask

  task automatic op16(input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] er,
                      input logic [15:0] erh, input logic [7:0] ef,
                      input string tag);
    q16.push_back('{er, erh, ef, tag});
    b16.iStart = 1'b1; b16.iOp = op; b16.iA = a; b16.iB = b;
    @(negedge clk);
    idle16();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle8();
    idle16();
    rst8  = 1'b1;
    rst16 = 1'b1;
    repeat (3) @(negedge clk);
    rst8  = 1'b0;
    rst16 = 1'b0;

    check("rst.oR",    32'(b8.oR),    32'h0);
    check("rst.oRH",   32'(b8.oRH),   32'h0);
    check("rst.oF",    32'(b8.oF),    32'h0);
    check("rst.oBusy", 32'(b8.oBusy), 32'h0);
    check("rst.oDone", 32'(b8.oDone), 32'h0);
    check("rst16.oF",  32'(b16.oF),   32'h0);

    // Arithmetic
    fload8(8'h00);
    check("fload00.oF", 32'(b8.oF), 32'h00);
    op8(4'h0, 8'h3A, 8'hC6, 8'h00, 8'h00, 8'h55, "add");
    op8(4'h1, 8'h0F, 8'h00, 8'h10, 8'h00, 8'h10, "adc");
    fload8(8'h01);
    check("fload01.oF", 32'(b8.oF), 32'h01);
    op8(4'h3, 8'h10, 8'h01, 8'h0E, 8'h00, 8'h10, "sbb");
    op8(4'h7, 8'h05, 8'h07, 8'h0E, 8'h00, 8'h91, "cmp");

    // Logical, increment/decrement
    op8(4'h4, 8'hF0, 8'h3C, 8'h30, 8'h00, 8'h14, "ana");
    op8(4'h5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h44, "xra");
    op8(4'h6, 8'h80, 8'h01, 8'h81, 8'h00, 8'h84, "ora");
    op8(4'h8, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h54, "inr");
    op8(4'h9, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h94, "dcr");

    // Rotates and CMC (only CY changes)
    fload8(8'h44);
    op8(4'hA, 8'h81, 8'h00, 8'h03, 8'h00, 8'h45, "rlc");
    op8(4'hE, 8'h00, 8'h00, 8'h03, 8'h00, 8'h44, "cmc");
    op8(4'hC, 8'h80, 8'h00, 8'h00, 8'h00, 8'h45, "ral");
    op8(4'hD, 8'h02, 8'h00, 8'h81, 8'h00, 8'h44, "rar");
    op8(4'hB, 8'h01, 8'h00, 8'h80, 8'h00, 8'h45, "rrc");

    // Flag load masks bits 1/3/5
    fload8(8'hFF);
    check("fload_ff.oF", 32'(b8.oF), 32'hD5);

    // iStart wins over simultaneous iFlagLoad
    q8.push_back('{16'h0000, 16'h0000, 8'h44, "start_vs_fload"});
    b8.iFlagLoad = 1'b1; b8.iF = 8'h01;
    start8(4'h5, 8'h00, 8'h00);

    // MUL 0xFF*0xFF with an ADD at cycle 3 that must be ignored
    q8.push_back('{16'h0001, 16'h00FE, 8'h81, "mul_ff"});
    start8(4'hF, 8'hFF, 8'hFF);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("mul_ff.busy_c%0d", c), 32'(b8.oBusy), 32'h1);
      if (c == 3) begin
        b8.iStart = 1'b1; b8.iOp = 4'h0; b8.iA = 8'h01; b8.iB = 8'h01;
      end else begin
        idle8();
      end
      @(negedge clk);
    end
    check("mul_ff.busy_end", 32'(b8.oBusy), 32'h0);

    // CMC after MUL: oR held, oRH cleared
    op8(4'hE, 8'h00, 8'h00, 8'h01, 8'h00, 8'h80, "cmc_after_mul");

    // Reset aborts a MUL with no oDone
    start8(4'hF, 8'h12, 8'h34);
    repeat (2) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort.oR",    32'(b8.oR),    32'h0);
    check("abort.oRH",   32'(b8.oRH),   32'h0);
    check("abort.oF",    32'(b8.oF),    32'h0);
    check("abort.oBusy", 32'(b8.oBusy), 32'h0);
    check("abort.oDone", 32'(b8.oDone), 32'h0);
    repeat (10) @(negedge clk);
    op8(4'h0, 8'h01, 8'h01, 8'h02, 8'h00, 8'h00, "add_after_rst");

    // DATASIZE = 16
    op16(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 8'h55, "add16");
    op16(4'hF, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 8'h05, "mul16");
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("mul16.busy_c%0d", c), 32'(b16.oBusy), 32'h1);
      @(negedge clk);
    end
    check("mul16.busy_end", 32'(b16.oBusy), 32'h0);

    repeat (5) @(negedge clk);
    check("q8_drained",  32'(q8.size()),  32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
